// File: rtl/data_sram_slave_pkg.sv
// data_sram_slave shared definitions.
// Default geometry, conf window offsets, select codes and byte merge.
package data_sram_slave_pkg;

    localparam int          RAM_AW_DEF  = 12;
    localparam logic [15:0] CONF_HI_DEF = 16'hBFAF;

    localparam logic [15:0] OFF_LED     = 16'hF000;
    localparam logic [15:0] OFF_SWITCH  = 16'hF004;
    localparam logic [15:0] OFF_TIMER   = 16'hF010;
    localparam logic [15:0] OFF_SCRATCH = 16'hF020;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_TIMER,
        SEL_SCRATCH
    } sel_e;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  we
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/data_sram_slave_bank.sv
// dsram_bank: single-port read-first RAM, 4 byte lanes.
// Output register updates only on enabled access; contents not reset.
module dsram_bank #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];
    logic [31:0] rdata_q;

    // Byte-lane write with old word captured on the same edge.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_slave.sv
// data_sram_slave: data-side SRAM responder with conf window.
// RAM bank plus LED/switch/timer/scratch registers, 1-cycle reads.
module data_sram_slave
    import data_sram_slave_pkg::*;
#(
    parameter int          RAM_AW  = RAM_AW_DEF,
    parameter logic [15:0] CONF_HI = CONF_HI_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch
);

    sel_e        sel;
    logic [31:0] conf_rd;
    logic [31:0] merged;
    logic [31:0] ram_rdata;
    logic        wr;
    logic        ram_en;

    logic [15:0] led_q, led_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] conf_rdata_q, conf_rdata_d;
    logic        ram_sel_q, ram_sel_d;
    logic [7:0]  sw_meta_q, sw_meta_d;
    logic [7:0]  sw_sync_q, sw_sync_d;

    // Address decode into RAM, a conf register or an unmapped hole.
    always_comb begin
        sel = SEL_RAM;
        if (data_sram_addr[31:16] == CONF_HI) begin
            case (data_sram_addr[15:0])
                OFF_LED:     sel = SEL_LED;
                OFF_SWITCH:  sel = SEL_SW;
                OFF_TIMER:   sel = SEL_TIMER;
                OFF_SCRATCH: sel = SEL_SCRATCH;
                default:     sel = SEL_NONE;
            endcase
        end
    end

    // Current (pre-write) value of the addressed conf register.
    always_comb begin
        conf_rd = '0;
        case (sel)
            SEL_LED:     conf_rd = {16'h0, led_q};
            SEL_SW:      conf_rd = {24'h0, sw_sync_q};
            SEL_TIMER:   conf_rd = timer_q;
            SEL_SCRATCH: conf_rd = scratch_q;
            default:     conf_rd = '0;
        endcase
    end

    assign wr     = data_sram_en && (data_sram_we != 4'h0);
    assign merged = byte_merge(conf_rd, data_sram_wdata, data_sram_we);
    assign ram_en = data_sram_en && !rst && (sel == SEL_RAM);

    // Next state for conf registers, timer, synchronizer and response steer.
    always_comb begin
        led_d        = led_q;
        timer_d      = timer_q + 32'd1;
        scratch_d    = scratch_q;
        conf_rdata_d = conf_rdata_q;
        ram_sel_d    = ram_sel_q;
        sw_meta_d    = switch;
        sw_sync_d    = sw_meta_q;
        if (data_sram_en) begin
            ram_sel_d    = (sel == SEL_RAM);
            conf_rdata_d = conf_rd;
        end
        if (wr) begin
            case (sel)
                SEL_LED:     led_d     = merged[15:0];
                SEL_TIMER:   timer_d   = merged;
                SEL_SCRATCH: scratch_d = merged;
                default:     ;
            endcase
        end
    end

    // Register update with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q        <= '0;
            timer_q      <= '0;
            scratch_q    <= '0;
            conf_rdata_q <= '0;
            ram_sel_q    <= 1'b0;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
        end else begin
            led_q        <= led_d;
            timer_q      <= timer_d;
            scratch_q    <= scratch_d;
            conf_rdata_q <= conf_rdata_d;
            ram_sel_q    <= ram_sel_d;
            sw_meta_q    <= sw_meta_d;
            sw_sync_q    <= sw_sync_d;
        end
    end

    dsram_bank #(
        .AW(RAM_AW)
    ) u_bank (
        .clk   (clk),
        .en    (ram_en),
        .we    (data_sram_we),
        .addr  (data_sram_addr[RAM_AW+1:2]),
        .wdata (data_sram_wdata),
        .rdata (ram_rdata)
    );

    assign data_sram_rdata = ram_sel_q ? ram_rdata : conf_rdata_q;
    assign led             = led_q;

endmodule

// File: tb/tb_data_sram_slave.sv
// tb_data_sram_slave: directed plus random check of data_sram_slave.
// Reference model tracks RAM words and conf registers per request.
module tb_data_sram_slave;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] led;
    logic [7:0]  sw;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [int];
    logic [31:0] m_timer;
    logic [31:0] m_scratch;
    logic [31:0] m_rdata;
    logic [15:0] m_led;
    logic [7:0]  m_sw1;
    logic [7:0]  m_sw2;
    bit          m_known = 1'b0;
    bit          cmp_on  = 1'b0;

    always #5 clk = ~clk;

    data_sram_slave #(
        .RAM_AW  (AW),
        .CONF_HI (16'hBFAF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .led             (led),
        .switch          (sw)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                               input logic [31:0] d,
                                               input logic [3:0] w);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // One clock edge of the reference model.
    task automatic model_edge(input logic r, input logic e, input logic [3:0] w,
                              input logic [31:0] a, input logic [31:0] d);
        logic [31:0] old;
        logic [31:0] nw;
        logic [31:0] nt;
        bit          known;
        bit          conf;
        int          idx;
        if (r) begin
            m_timer   = 0;
            m_scratch = 0;
            m_led     = 0;
            m_rdata   = 0;
            m_known   = 1'b1;
            m_sw1     = 0;
            m_sw2     = 0;
            return;
        end
        known = 1'b1;
        old   = 0;
        idx   = int'(a[AW+1:2]);
        conf  = (a[31:16] == 16'hBFAF);
        if (conf) begin
            case (a[15:0])
                16'hF000: old = {16'h0, m_led};
                16'hF004: old = {24'h0, m_sw2};
                16'hF010: old = m_timer;
                16'hF020: old = m_scratch;
                default:  old = 0;
            endcase
        end else if (m_mem.exists(idx)) begin
            old = m_mem[idx];
        end else begin
            known = 1'b0;
        end
        nt = m_timer + 32'd1;
        if (e) begin
            m_rdata = old;
            m_known = known;
            if (w != 4'h0) begin
                nw = lane_merge(old, d, w);
                if (conf) begin
                    case (a[15:0])
                        16'hF000: m_led = nw[15:0];
                        16'hF010: nt = nw;
                        16'hF020: m_scratch = nw;
                        default:  ;
                    endcase
                end else if (known) begin
                    m_mem[idx] = nw;
                end else if (w == 4'hF) begin
                    m_mem[idx] = d;
                end
            end
        end
        m_timer = nt;
        m_sw2   = m_sw1;
        m_sw1   = sw;
    endtask

    task automatic tick(input logic r, input logic e, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
        rst   = r;
        en    = e;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        model_edge(r, e, w, a, d);
        #1;
    endtask

    // Every-cycle comparison against the reference model.
    always @(negedge clk) begin
        if (cmp_on) begin
            if (m_known) chk("rdata_model", rdata, m_rdata);
            chk("led_model", {16'h0, led}, {16'h0, m_led});
        end
    end

    initial begin
        logic        r;
        logic        e;
        logic [3:0]  w;
        logic [31:0] a;
        int          k;
        sw = 8'h00;
        tick(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        tick(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        cmp_on = 1'b1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_led", {16'h0, led}, 32'h0);

        tick(1'b0, 1'b1, 4'hF, 32'h0000_0100, 32'h1122_3344);
        tick(1'b0, 1'b1, 4'b0010, 32'h0000_0100, 32'h0000_AA00);
        tick(1'b0, 1'b1, 4'h0, 32'h0000_0100, 32'h0);
        chk("byte_enable", rdata, 32'h1122_AA44);
        tick(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("rdata_hold", rdata, 32'h1122_AA44);

        tick(1'b0, 1'b1, 4'hF, 32'h0000_0200, 32'hDEAD_BEEF);
        tick(1'b0, 1'b1, 4'hF, 32'h0000_0200, 32'h0);
        chk("read_first", rdata, 32'hDEAD_BEEF);
        tick(1'b0, 1'b1, 4'h0, 32'h0000_0200, 32'h0);
        chk("b2b_read", rdata, 32'h0);

        tick(1'b0, 1'b1, 4'hF, 32'hBFAF_F010, 32'hFFFF_FFFE);
        tick(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b1, 4'h0, 32'hBFAF_F010, 32'h0);
        chk("timer_max", rdata, 32'hFFFF_FFFF);
        tick(1'b0, 1'b1, 4'h0, 32'hBFAF_F010, 32'h0);
        chk("timer_wrap", rdata, 32'h0);

        tick(1'b0, 1'b1, 4'hF, 32'hBFAF_F000, 32'h1234_5678);
        chk("led_out", {16'h0, led}, 32'h0000_5678);
        tick(1'b0, 1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
        chk("led_read", rdata, 32'h0000_5678);

        sw = 8'hA5;
        tick(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b1, 4'h0, 32'hBFAF_F004, 32'h0);
        chk("switch_sync", rdata, 32'h0000_00A5);
        tick(1'b0, 1'b1, 4'hF, 32'hBFAF_F004, 32'hFFFF_FFFF);
        tick(1'b0, 1'b1, 4'h0, 32'hBFAF_F004, 32'h0);
        chk("switch_ro", rdata, 32'h0000_00A5);

        tick(1'b0, 1'b1, 4'hF, 32'hBFAF_F008, 32'h1357_9BDF);
        tick(1'b0, 1'b1, 4'h0, 32'hBFAF_F008, 32'h0);
        chk("unmapped", rdata, 32'h0);
        tick(1'b0, 1'b1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D);
        tick(1'b0, 1'b1, 4'h0, 32'h4 << AW, 32'h0);
        chk("alias", rdata, 32'hCAFE_F00D);

        tick(1'b0, 1'b1, 4'hF, 32'hBFAF_F020, 32'h0000_55AA);
        tick(1'b0, 1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
        chk("scratch_rw", rdata, 32'h0000_55AA);
        tick(1'b1, 1'b1, 4'hF, 32'hBFAF_F020, 32'h7777_7777);
        chk("reset_wins", rdata, 32'h0);
        tick(1'b0, 1'b1, 4'h0, 32'hBFAF_F010, 32'h0);
        chk("timer_restart", rdata, 32'h0);
        tick(1'b0, 1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
        chk("scratch_reset", rdata, 32'h0);
        tick(1'b0, 1'b1, 4'h0, 32'hBFAF_F010, 32'h0);
        chk("timer_count", rdata, 32'h2);

        for (int i = 0; i < 32; i++) begin
            tick(1'b0, 1'b1, 4'hF, 32'(i) << 2, $urandom);
        end

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 60) == 0) sw = 8'($urandom);
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            k = $urandom_range(0, 9);
            a = $urandom;
            if (k < 6) begin
                a[AW+1:2] = 12'($urandom_range(0, 31));
                if (a[31:16] == 16'hBFAF) a[31] = 1'b0;
            end else begin
                a[31:16] = 16'hBFAF;
                case (k)
                    6: a[15:0] = 16'hF000;
                    7: a[15:0] = 16'hF004;
                    8: a[15:0] = ($urandom_range(0, 1) == 1) ? 16'hF010 : 16'hF020;
                    default: ;
                endcase
            end
            tick(r, e, w, a, $urandom);
        end

        tick(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
